dot_product_streamer: RTL
=========================

DOT_PRODUCT_STREAMER -- requirements
Module: dot_product_streamer

Interface
REQ-001 SHALL have parameter BITS, default 8: element and result width.
REQ-002 SHALL have parameter LENGTH, default 10: elements per vector (2..255).
REQ-003 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1: vector element write strobe.
REQ-006 SHALL have port wr_sel  input  1: target vector; 0 = A, 1 = B.
REQ-007 SHALL have port wr_addr  input  8: element index.
REQ-008 SHALL have port wr_data  input  BITS: element value.
REQ-009 SHALL have port start  input  1: request one dot-product run.
REQ-010 SHALL have port busy  output  1: run in progress.
REQ-011 SHALL have port s_valid  output  1: stream valid to the multiply-accumulate unit.
REQ-012 SHALL have port s_a  output  BITS: stream operand A.
REQ-013 SHALL have port s_b  output  BITS: stream operand B.
REQ-014 SHALL have port r_valid  input  1: result strobe from the multiply-accumulate unit.
REQ-015 SHALL have port r_data  input  BITS: result from the multiply-accumulate unit.
REQ-016 SHALL have port done  output  1: one-cycle pulse, run finished.
REQ-017 SHALL have port result  output  BITS: captured dot product, held until next capture.
REQ-018 SHALL have port timeout  output  1: sticky flag, result never arrived.

Function
REQ-019 SHALL store A and B as LENGTH x BITS register arrays; a write with wr_en=1 and wr_addr<LENGTH SHALL update the selected element on the next clk edge.
REQ-020 SHALL ignore writes with wr_addr>=LENGTH, and all writes while busy=1.
REQ-021 SHALL implement FSM states IDLE, STREAM, WAIT, DONE.
REQ-022 IDLE: start=1 -> STREAM, index cleared to 0, busy=1 from the next cycle; start while not IDLE SHALL be ignored.
REQ-023 STREAM: s_valid=1 for exactly LENGTH consecutive cycles with no gap, emitting s_a=A[i], s_b=B[i] for i=0..LENGTH-1 in order; after i=LENGTH-1 -> WAIT.
REQ-024 s_valid SHALL be 0 and s_a/s_b SHALL be 0 in every state except STREAM.
REQ-025 The consumer returns r_valid exactly 3 cycles after the last s_valid cycle; WAIT SHALL accept r_valid on any cycle and capture r_data into result, then -> DONE.
REQ-026 WAIT SHALL count cycles; if r_valid has not arrived after 8 cycles in WAIT, set timeout=1, leave result unchanged, -> DONE.
REQ-027 DONE: done=1 for one cycle, busy=0 in that cycle, -> IDLE; start in DONE SHALL be ignored.
REQ-028 r_valid outside WAIT SHALL be ignored.
REQ-029 Arithmetic is performed by the consumer; result is the raw BITS-wide r_data (modulo 2^BITS, unsigned), no widening.
REQ-030 timeout SHALL clear only on a new start accepted in IDLE.
REQ-031 Minimum start-to-start period: LENGTH+5 cycles (IDLE, LENGTH STREAM, 3 WAIT, DONE).

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, index 0, busy=0, s_valid=0, s_a=0, s_b=0, done=0, result=0, timeout=0, all A/B elements 0.
REQ-033 Reset asserted mid-STREAM or mid-WAIT SHALL abort the run; first cycle after release is IDLE with all outputs at reset values.

Structure
REQ-034 A shared package dot_product_pkg SHALL hold the FSM state enum and the WAIT timeout constant (8).
REQ-035 The two vector arrays SHALL be two instances of one sub-module vector_bank (parameters BITS, LENGTH; write port; combinational read by index).

Verification
REQ-036 A=1..10, B=all 1, start, consumer connected -> s_valid high 10 cycles, done after 14 cycles, result=55.
REQ-037 A=all 20, B=all 2 (BITS=8) -> result=400 mod 256=144.
REQ-038 No r_valid returned -> timeout=1, done pulse after 8 WAIT cycles, result unchanged from prior run.
REQ-039 start held high continuously -> runs back to back every 15 cycles, s_valid low at least 5 cycles between bursts.
REQ-040 write to A[3]=99 while busy and write to wr_addr=10 -> both ignored, next run result matches stored vectors.
REQ-041 rst_n low at 5th STREAM cycle -> s_valid=0 immediately, no done, result=0, vectors cleared.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product streamer.
//   state_e      : controller FSM states
//   WAIT_TIMEOUT : WAIT cycles allowed for the consumer's result before giving up
//   WCNT_W       : width of the WAIT cycle counter
package dot_product_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int WAIT_TIMEOUT = 8;
  localparam int WCNT_W       = $clog2(WAIT_TIMEOUT);

endpackage

// File: rtl/dot_product_streamer_vector_bank.sv
// vector_bank: LENGTH x BITS register array with one write port and a
// combinational read port.
//   clk, rst_n : clock, async active-low reset (clears every element)
//   wr_en      : write strobe, already qualified by the caller
//   wr_addr    : element index; indices >= LENGTH match no element and are dropped
//   wr_data    : element value
//   rd_idx     : read index; out-of-range reads return 0
//   rd_data    : element at rd_idx
module vector_bank #(
  parameter int BITS   = 8,
  parameter int LENGTH = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic [7:0]      rd_idx,
  output logic [BITS-1:0] rd_data
);

  logic [LENGTH-1:0][BITS-1:0] r_mem;

  // Per-element decode: an address past the end simply matches nothing.
  for (genvar g = 0; g < LENGTH; g++) begin : g_elem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_mem[g] <= '0;
      else if (wr_en && (wr_addr == 8'(g)))   r_mem[g] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LENGTH; i++)
      if (rd_idx == 8'(i)) rd_data = r_mem[i];
  end

endmodule

// File: rtl/dot_product_streamer.sv
// dot_product_streamer: holds vectors A and B, streams A[i]/B[i] pairs to an
// external multiply-accumulate unit, then waits for its result.
//   clk, rst_n         : clock, async active-low reset
//   wr_en/sel/addr/data: element write port (sel 0 = A, 1 = B), ignored while busy
//   start              : request a run (honoured only in IDLE)
//   busy               : run in progress (STREAM or WAIT)
//   s_valid, s_a, s_b  : operand stream, zero outside STREAM
//   r_valid, r_data    : result return from the consumer (only seen in WAIT)
//   done               : one-cycle pulse when a run finishes
//   result             : last captured r_data
//   timeout            : sticky, set when WAIT expired; cleared by the next start
module dot_product_streamer
  import dot_product_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int LENGTH = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [7:0]      wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            start,
  output logic            busy,
  output logic            s_valid,
  output logic [BITS-1:0] s_a,
  output logic [BITS-1:0] s_b,
  input  logic            r_valid,
  input  logic [BITS-1:0] r_data,
  output logic            done,
  output logic [BITS-1:0] result,
  output logic            timeout
);

  localparam logic [7:0]        IDX_LAST  = 8'(LENGTH - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);

  state_e            r_state;
  logic [7:0]        r_idx;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_busy, r_s_valid, r_done, r_timeout;
  logic [BITS-1:0]   r_s_a, r_s_b, r_result;

  logic [7:0]      w_rd_idx;
  logic [BITS-1:0] w_a, w_b;
  logic            w_wr_a, w_wr_b;

  assign w_wr_a = wr_en && !r_busy && !wr_sel;
  assign w_wr_b = wr_en && !r_busy &&  wr_sel;

  // Outputs are registered, so the banks are read one element ahead:
  // element 0 while IDLE (loaded on start), idx+1 while STREAM.
  assign w_rd_idx = (r_state == ST_STREAM) ? r_idx + 8'd1 : 8'd0;

  vector_bank #(.BITS(BITS), .LENGTH(LENGTH)) u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_a),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (w_rd_idx),
    .rd_data (w_a)
  );

  vector_bank #(.BITS(BITS), .LENGTH(LENGTH)) u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_b),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (w_rd_idx),
    .rd_data (w_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_busy    <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_a     <= '0;
      r_s_b     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_STREAM;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
            r_s_valid <= 1'b1;
            r_s_a     <= w_a;
            r_s_b     <= w_b;
          end
        end
        ST_STREAM: begin
          if (r_idx == IDX_LAST) begin
            r_state   <= ST_WAIT;
            r_wcnt    <= '0;
            r_s_valid <= 1'b0;
            r_s_a     <= '0;
            r_s_b     <= '0;
          end else begin
            r_idx <= r_idx + 8'd1;
            r_s_a <= w_a;
            r_s_b <= w_b;
          end
        end
        ST_WAIT: begin
          // A result on the last allowed cycle still wins over the timeout.
          if (r_valid) begin
            r_result <= r_data;
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (r_wcnt == WCNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign s_valid = r_s_valid;
  assign s_a     = r_s_a;
  assign s_b     = r_s_b;
  assign done    = r_done;
  assign result  = r_result;
  assign timeout = r_timeout;

endmodule
